// File: rtl/fwd_bypass_unit.sv
// Operand bypass unit. A DEPTH-entry write scoreboard resolves rs_a/rs_b to RF, ALU or load data.
// Lookup has zero latency. stall holds upstream while a matching load is pending; issue is dropped while stalled.
module fwd_bypass_unit #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 3,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              issue,
  input  logic              issue_wr,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic              issue_load,
  input  logic [DATA_W-1:0] issue_data,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [REG_AW-1:0] rs_a,
  input  logic [REG_AW-1:0] rs_b,
  input  logic [DATA_W-1:0] rf_a,
  input  logic [DATA_W-1:0] rf_b,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [1:0]        sel_a,
  output logic [1:0]        sel_b,
  output logic              stall,
  output logic              lost_load
);

  typedef struct packed {
    logic [DATA_W-1:0] dat;
    logic [1:0]        sel;
    logic              req;
  } res_t;

  logic [DEPTH-1:0]  v_q;
  logic [DEPTH-1:0]  pend_q;
  logic [DEPTH-1:0]  ld_q;
  logic [REG_AW-1:0] rd_q  [DEPTH];
  logic [DATA_W-1:0] dat_q [DEPTH];
  logic              lost_q;

  logic has_pend;
  int   oldest;
  logic fill;
  res_t res_a;
  res_t res_b;

  // Load data always belongs to the oldest outstanding load.
  always_comb begin
    has_pend = 1'b0;
    oldest   = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (v_q[i] && pend_q[i]) begin
        has_pend = 1'b1;
        oldest   = i;
      end
    end
  end

  assign fill = mem_valid && has_pend;

  // Walk oldest to youngest so the youngest match is the one that sticks.
  function automatic res_t resolve(input logic [REG_AW-1:0] rs, input logic [DATA_W-1:0] rf);
    res_t r;
    r.dat = rf;
    r.sel = 2'b00;
    r.req = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (v_q[i] && rd_q[i] == rs) begin
        if (!pend_q[i]) begin
          r.dat = dat_q[i];
          r.sel = ld_q[i] ? 2'b10 : 2'b01;
          r.req = 1'b0;
        end else if (mem_valid && i == oldest) begin
          r.dat = mem_data;
          r.sel = 2'b10;
          r.req = 1'b0;
        end else begin
          r.dat = rf;
          r.sel = 2'b00;
          r.req = 1'b1;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    res_a = resolve(rs_a, rf_a);
    res_b = resolve(rs_b, rf_b);
  end

  assign out_a     = res_a.dat;
  assign sel_a     = res_a.sel;
  assign out_b     = res_b.dat;
  assign sel_b     = res_b.sel;
  assign stall     = res_a.req | res_b.req;
  assign lost_load = lost_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q    <= '0;
      pend_q <= '0;
      ld_q   <= '0;
      lost_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]  <= '0;
        dat_q[i] <= '0;
      end
    end else if (flush) begin
      v_q    <= '0;
      pend_q <= '0;
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        v_q[i]   <= v_q[i-1];
        rd_q[i]  <= rd_q[i-1];
        ld_q[i]  <= ld_q[i-1];
        pend_q[i] <= pend_q[i-1] && !(fill && oldest == i - 1);
        dat_q[i] <= (fill && oldest == i - 1) ? mem_data : dat_q[i-1];
      end
      if (issue && issue_wr && !stall) begin
        v_q[0]    <= 1'b1;
        rd_q[0]   <= issue_rd;
        ld_q[0]   <= issue_load;
        pend_q[0] <= issue_load;
        dat_q[0]  <= issue_load ? '0 : issue_data;
      end else begin
        v_q[0]    <= 1'b0;
        rd_q[0]   <= '0;
        ld_q[0]   <= 1'b0;
        pend_q[0] <= 1'b0;
        dat_q[0]  <= '0;
      end
      // Data with nowhere to go, or a load retiring before its data came back.
      if ((mem_valid && !has_pend) ||
          (v_q[DEPTH-1] && pend_q[DEPTH-1] && !(fill && oldest == DEPTH - 1)))
        lost_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fwd_bypass_unit.sv
// Directed bench for fwd_bypass_unit with DEPTH=3 so a filled load can be observed before it retires.
module tb_fwd_bypass_unit;
  localparam int DATA_W = 8;
  localparam int REG_AW = 3;
  localparam int DEPTH  = 3;

  logic              clk = 1'b0;
  logic              rst_n, flush, issue, issue_wr, issue_load, mem_valid;
  logic [REG_AW-1:0] issue_rd, rs_a, rs_b;
  logic [DATA_W-1:0] issue_data, mem_data, rf_a, rf_b, out_a, out_b;
  logic [1:0]        sel_a, sel_b;
  logic              stall, lost_load;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fwd_bypass_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .issue(issue), .issue_wr(issue_wr),
    .issue_rd(issue_rd), .issue_load(issue_load), .issue_data(issue_data),
    .mem_valid(mem_valid), .mem_data(mem_data), .rs_a(rs_a), .rs_b(rs_b),
    .rf_a(rf_a), .rf_b(rf_b), .out_a(out_a), .out_b(out_b), .sel_a(sel_a),
    .sel_b(sel_b), .stall(stall), .lost_load(lost_load)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    issue = 0; issue_wr = 0; issue_load = 0; issue_rd = '0; issue_data = '0;
    mem_valid = 0; mem_data = '0; flush = 0;
  endtask

  task automatic do_issue(input logic [REG_AW-1:0] rd, input logic ld, input logic [DATA_W-1:0] d);
    issue = 1; issue_wr = 1; issue_rd = rd; issue_load = ld; issue_data = d;
    tick();
    idle();
  endtask

  initial begin
    idle();
    rst_n = 0; rs_a = 3'd3; rs_b = 3'd0; rf_a = 8'h11; rf_b = 8'h22;
    tick(); tick();
    rst_n = 1;
    #1;
    chk("rst_out_a", out_a, 8'h11);
    chk("rst_sel_a", sel_a, 2'b00);
    chk("rst_stall", stall, 1'b0);
    chk("rst_lost", lost_load, 1'b0);

    // ALU forwarding on both operands, then ageing out
    do_issue(3'd2, 1'b0, 8'hA5);
    rs_a = 3'd2; rs_b = 3'd2; rf_a = 8'h77; rf_b = 8'h66;
    #1;
    chk("alu_out_a", out_a, 8'hA5);
    chk("alu_out_b", out_b, 8'hA5);
    chk("alu_sel_a", sel_a, 2'b01);
    chk("alu_sel_b", sel_b, 2'b01);
    for (int i = 0; i < DEPTH - 1; i++) tick();
    chk("alu_oldest_sel", sel_a, 2'b01);
    tick();
    chk("alu_retired_sel", sel_a, 2'b00);
    chk("alu_retired_out", out_b, 8'h66);

    // Youngest producer wins
    do_issue(3'd1, 1'b0, 8'h10);
    do_issue(3'd1, 1'b0, 8'h20);
    rs_a = 3'd1;
    #1;
    chk("young_out_a", out_a, 8'h20);
    chk("young_sel_a", sel_a, 2'b01);

    // Register 0 forwards like any other
    do_issue(3'd0, 1'b0, 8'h5A);
    rs_b = 3'd0;
    #1;
    chk("r0_out_b", out_b, 8'h5A);
    chk("r0_sel_b", sel_b, 2'b01);
    for (int i = 0; i < DEPTH; i++) tick();

    // Load: stall, bypass on return, then stored value
    rs_a = 3'd3;
    do_issue(3'd4, 1'b1, 8'hEE);
    rs_b = 3'd4; rf_b = 8'h99;
    #1;
    chk("ld_stall", stall, 1'b1);
    chk("ld_stall_sel_b", sel_b, 2'b00);
    chk("ld_stall_out_b", out_b, 8'h99);
    tick();
    mem_valid = 1; mem_data = 8'h3C;
    #1;
    chk("ld_byp_out_b", out_b, 8'h3C);
    chk("ld_byp_sel_b", sel_b, 2'b10);
    chk("ld_byp_stall", stall, 1'b0);
    tick();
    idle();
    #1;
    chk("ld_stored_out_b", out_b, 8'h3C);
    chk("ld_stored_sel_b", sel_b, 2'b10);
    tick();
    chk("ld_retire_lost", lost_load, 1'b0);
    chk("ld_retire_sel_b", sel_b, 2'b00);

    // Flush drops a pending load; late data is then lost
    do_issue(3'd5, 1'b1, 8'h00);
    flush = 1;
    tick();
    idle();
    rs_a = 3'd5;
    #1;
    chk("flush_sel_a", sel_a, 2'b00);
    chk("flush_stall", stall, 1'b0);
    chk("flush_lost0", lost_load, 1'b0);
    mem_valid = 1; mem_data = 8'h44;
    tick();
    idle();
    chk("flush_lost1", lost_load, 1'b1);

    // A write presented while stalled is not recorded
    do_issue(3'd3, 1'b1, 8'h00);
    rs_a = 3'd3;
    issue = 1; issue_wr = 1; issue_rd = 3'd7; issue_data = 8'h42;
    #1;
    chk("stl_stall", stall, 1'b1);
    tick();
    idle();
    rs_a = 3'd7; rf_a = 8'h13;
    #1;
    chk("stl_drop_sel", sel_a, 2'b00);
    chk("stl_drop_out", out_a, 8'h13);
    for (int i = 0; i < DEPTH; i++) tick();

    // Unreturned load retires -> sticky lost_load until reset
    rst_n = 0;
    tick();
    rst_n = 1;
    #1;
    chk("rst2_lost", lost_load, 1'b0);
    rs_a = 3'd0; rs_b = 3'd1;
    do_issue(3'd6, 1'b1, 8'h00);
    for (int i = 0; i < DEPTH - 1; i++) tick();
    chk("unret_lost_before", lost_load, 1'b0);
    tick();
    chk("unret_lost_after", lost_load, 1'b1);
    tick(); tick();
    chk("unret_lost_sticky", lost_load, 1'b1);
    rst_n = 0;
    tick();
    rst_n = 1;
    #1;
    chk("rst3_lost", lost_load, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
